// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the ALU sequencer slice: data/op widths, the ALU
// op-code map, the multiply iteration count and the sequencer state type.
// No ports (package).
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int DATA_W   = 32;
    localparam int OP_W     = 4;
    localparam int MUL_ITER = 32;
    localparam int CNT_W    = 6;

    localparam logic [OP_W-1:0] OP_OR  = 4'd0;
    localparam logic [OP_W-1:0] OP_AND = 4'd1;
    localparam logic [OP_W-1:0] OP_NOT = 4'd2;
    localparam logic [OP_W-1:0] OP_ADD = 4'd3;
    localparam logic [OP_W-1:0] OP_SUB = 4'd4;
    localparam logic [OP_W-1:0] OP_MUL = 4'd5;

    // Count value seen on the edge that performs the final multiply pass.
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_ITER - 1);

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_EXEC = 2'd1,
        SEQ_MUL  = 2'd2,
        SEQ_DONE = 2'd3
    } seq_state_t;

endpackage

// File: rtl/alu_unit.sv
// ---------------------------------------------------------------------------
// alu_unit
// Wrapper joining the sequencer to the ALU it controls.
// Ports:
//   clock, clear_n  - clock and asynchronous active-low reset
//   start, op, a, b - operation request
//   busy, done      - handshake status
//   result          - completed result
// ---------------------------------------------------------------------------
module alu_unit
    import cpu_pkg::*;
(
    input  logic              clock,
    input  logic              clear_n,
    input  logic              start,
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    logic [DATA_W-1:0] w_aluA;
    logic [DATA_W-1:0] w_aluB;
    logic [OP_W-1:0]   w_aluOp;
    logic [DATA_W-1:0] w_aluResult;

    alu_sequencer u_seq (
        .clock      (clock),
        .clear_n    (clear_n),
        .start      (start),
        .op         (op),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .alu_a      (w_aluA),
        .alu_b      (w_aluB),
        .alu_op     (w_aluOp),
        .alu_result (w_aluResult)
    );

    cpu_alu u_alu (
        .i_a      (w_aluA),
        .i_b      (w_aluB),
        .i_op     (w_aluOp),
        .o_result (w_aluResult)
    );

endmodule

// File: rtl/cpu_alu.sv
// ---------------------------------------------------------------------------
// cpu_alu
// Purely combinational 32-bit ALU driven by the sequencer.
// Ports:
//   i_a, i_b  - operands
//   i_op      - op select (OR, AND, NOT A, ADD, SUB); every other code
//               returns zero, including the MUL code, which the sequencer
//               never presents here
//   o_result  - combinational result, modulo 2^32
// ---------------------------------------------------------------------------
module cpu_alu
    import cpu_pkg::*;
(
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [OP_W-1:0]   i_op,
    output logic [DATA_W-1:0] o_result
);

    always_comb begin
        o_result = '0;
        case (i_op)
            OP_OR:   o_result = i_a | i_b;
            OP_AND:  o_result = i_a & i_b;
            OP_NOT:  o_result = ~i_a;
            OP_ADD:  o_result = i_a + i_b;
            OP_SUB:  o_result = i_a - i_b;
            default: o_result = '0;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
// Multi-cycle controller that owns the ALU inputs and runs one operation per
// start/done handshake. Single-pass ops take one ALU cycle; MUL is built
// from 32 shift-and-add passes through the ALU's ADD.
// Ports:
//   clock, clear_n  - clock and asynchronous active-low reset
//   start, op, a, b - request, sampled only while idle
//   busy            - high in every non-idle state
//   done            - one-cycle completion pulse
//   result          - registered result, held until the next completion
//   alu_a/alu_b/alu_op - drive the external ALU
//   alu_result      - combinational ALU output
// ---------------------------------------------------------------------------
module alu_sequencer
    import cpu_pkg::*;
(
    input  logic              clock,
    input  logic              clear_n,
    input  logic              start,
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_result
);

    seq_state_t        r_state;
    seq_state_t        w_nextState;

    logic [DATA_W-1:0] r_aQ;
    logic [DATA_W-1:0] r_bQ;
    logic [OP_W-1:0]   r_opQ;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_mcand;
    logic [DATA_W-1:0] r_mplier;
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] r_result;

    logic              w_mulLast;
    logic [DATA_W-1:0] w_accNext;

    // The ALU adds acc+mcand every MUL cycle; the sum is only kept when the
    // current multiplier bit is set.
    assign w_accNext = r_mplier[0] ? alu_result : r_acc;
    assign w_mulLast = (r_count == MUL_LAST);

    // Status comes straight from the state register so it cannot glitch.
    assign busy   = (r_state != SEQ_IDLE);
    assign done   = (r_state == SEQ_DONE);
    assign result = r_result;

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            r_state <= SEQ_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        alu_a       = r_aQ;
        alu_b       = r_bQ;
        alu_op      = r_opQ;
        case (r_state)
            SEQ_IDLE: begin
                if (start) begin
                    w_nextState = (op == OP_MUL) ? SEQ_MUL : SEQ_EXEC;
                end
            end
            SEQ_EXEC: begin
                w_nextState = SEQ_DONE;
            end
            SEQ_MUL: begin
                alu_a  = r_acc;
                alu_b  = r_mcand;
                alu_op = OP_ADD;
                if (w_mulLast) begin
                    w_nextState = SEQ_DONE;
                end
            end
            SEQ_DONE: begin
                w_nextState = SEQ_IDLE;
            end
            default: begin
                w_nextState = SEQ_IDLE;
            end
        endcase
    end

    // Operand capture and the shift-and-add datapath. result only moves on
    // the edge leaving EXEC or the final MUL pass, so it stays stable while
    // done is high and until the next operation completes.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            r_aQ     <= '0;
            r_bQ     <= '0;
            r_opQ    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_count  <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                SEQ_IDLE: begin
                    if (start) begin
                        r_aQ  <= a;
                        r_bQ  <= b;
                        r_opQ <= op;
                        if (op == OP_MUL) begin
                            r_acc    <= '0;
                            r_mcand  <= a;
                            r_mplier <= b;
                            r_count  <= '0;
                        end
                    end
                end
                SEQ_EXEC: begin
                    r_result <= alu_result;
                end
                SEQ_MUL: begin
                    r_acc    <= w_accNext;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count + 1'b1;
                    if (w_mulLast) begin
                        r_result <= w_accNext;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
